// File: rtl/conv_encoder_stream.sv
`default_nettype none
// ============================================================================
//  Module   : conv_encoder_stream
//  Brief    : Streaming rate 1/2 or 1/3 convolutional encoder with runtime
//             polynomials and constraint length, valid/ready in and out.
//             CONV_ENC_TAIL_TERM_EN adds zero-tail termination.
//  Revision : 1.0 - initial release
// ============================================================================
module conv_encoder_stream #(
    parameter int K_MAX       = 9,
    parameter int R_MAX       = 3,
    parameter int IN_W        = 8,
    parameter int FRAME_BEATS = 16
) (
    input  logic                              sys_clk,
    input  logic                              rst,
    input  logic                              i_start,
    input  logic                              i_code_rate,
    input  logic [K_MAX*R_MAX-1:0]            i_gen_poly_flat,
    input  logic [$clog2(K_MAX+1)-1:0]        i_constraint_len,
    input  logic [K_MAX-2:0]                  i_prv_encoder_state,
    input  logic [IN_W-1:0]                   i_data,
    input  logic                              i_valid,
    output logic                              o_ready,
    output logic [R_MAX*IN_W-1:0]             o_data,
    output logic [$clog2(R_MAX*IN_W+1)-1:0]   o_nbits,
    output logic                              o_valid,
    input  logic                              i_ready,
    output logic                              o_last,
    output logic [K_MAX-2:0]                  o_final_state,
    output logic                              o_done
);
    localparam int c_kw  = $clog2(K_MAX+1);
    localparam int c_nbw = $clog2(R_MAX*IN_W+1);
    localparam int c_bw  = $clog2(FRAME_BEATS+1);
    localparam int c_tw  = $clog2(K_MAX+IN_W+1);
    localparam logic [c_kw-1:0] c_k_min     = c_kw'(3);
    localparam logic [c_kw-1:0] c_k_max     = c_kw'(K_MAX);
    localparam logic [c_bw-1:0] c_last_beat = c_bw'(FRAME_BEATS-1);
    localparam logic [c_tw-1:0] c_in_w      = c_tw'(IN_W);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_RUN   = 3'd1,
        S_TAIL  = 3'd2,
        S_FLUSH = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    state_t                r_fsm;
    logic                  r_rate;
    logic [K_MAX-1:0]      r_poly [R_MAX];
    logic [K_MAX-2:0]      r_smask;
    logic [K_MAX-2:0]      r_sr;
    logic [c_bw-1:0]       r_beat;
    logic [c_tw-1:0]       r_tail_left;
    logic [R_MAX*IN_W-1:0] r_data;
    logic [c_nbw-1:0]      r_nbits;
    logic                  r_valid;
    logic                  r_last;
    logic [K_MAX-2:0]      r_final;
    logic                  r_done;

    logic [c_kw-1:0]       w_k;
    logic [K_MAX-1:0]      w_kmask;
    logic [K_MAX-1:0]      w_poly_in [R_MAX];
    logic [R_MAX*IN_W-1:0] w_enc;
    logic [K_MAX-2:0]      w_sr_next;
    logic [c_tw-1:0]       w_nvalid;
    logic [c_nbw-1:0]      w_nbits;
    logic                  w_out_free;
    logic                  w_accept;
    logic                  w_tail_last;

    // Config decode: clamp K, mask polys to K taps, silence inactive streams.
    always_comb begin
        w_k = (i_constraint_len < c_k_min || i_constraint_len > c_k_max) ? c_k_max : i_constraint_len;
        for (int k = 0; k < K_MAX; k++) begin
            w_kmask[k] = (k < int'(w_k));
        end
        for (int j = 0; j < R_MAX; j++) begin
            w_poly_in[j] = (j < (i_code_rate ? 3 : 2)) ? (i_gen_poly_flat[K_MAX*j +: K_MAX] & w_kmask) : '0;
        end
    end

    assign w_out_free  = !r_valid || i_ready;
    assign o_ready     = (r_fsm == S_RUN) && w_out_free;
    assign w_accept    = i_valid && o_ready;
    assign w_tail_last = (r_tail_left <= c_in_w);
    assign w_nvalid    = (r_fsm == S_TAIL && w_tail_last) ? r_tail_left : c_in_w;
    assign w_nbits     = c_nbw'(int'(w_nvalid) * (r_rate ? 3 : 2));

    always_comb begin
        logic [K_MAX-2:0] w_sr_it;
        logic [K_MAX-1:0] w_win;
        logic             w_bit;
        w_sr_it = r_sr;
        w_win   = '0;
        w_bit   = 1'b0;
        w_enc   = '0;
        for (int i = 0; i < IN_W; i++) begin
            w_bit = (r_fsm == S_TAIL) ? 1'b0 : i_data[i];
            w_win = {w_sr_it, w_bit};
            if (i < int'(w_nvalid)) begin
                for (int j = 0; j < R_MAX; j++) begin
                    w_enc[R_MAX*i+j] = ^(w_win & r_poly[j]);
                end
            end
            // Only the K-1 live history bits are kept so a zero tail clears the register.
            w_sr_it = {w_sr_it[K_MAX-3:0], w_bit} & r_smask;
        end
        w_sr_next = w_sr_it;
    end

    always_ff @(posedge sys_clk or negedge rst) begin
        if (!rst) begin
            r_fsm       <= S_IDLE;
            r_rate      <= 1'b0;
            for (int j = 0; j < R_MAX; j++) begin
                r_poly[j] <= '0;
            end
            r_smask     <= '0;
            r_sr        <= '0;
            r_beat      <= '0;
            r_tail_left <= '0;
            r_data      <= '0;
            r_nbits     <= '0;
            r_valid     <= 1'b0;
            r_last      <= 1'b0;
            r_final     <= '0;
            r_done      <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_fsm)
                S_IDLE: begin
                    if (i_start) begin
                        r_rate      <= i_code_rate;
                        r_poly      <= w_poly_in;
                        r_smask     <= w_kmask[K_MAX-1:1];
                        r_sr        <= i_prv_encoder_state & w_kmask[K_MAX-1:1];
                        r_beat      <= '0;
                        r_tail_left <= c_tw'(w_k) - c_tw'(1);
                        r_fsm       <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_accept) begin
                        r_data  <= w_enc;
                        r_nbits <= w_nbits;
                        r_valid <= 1'b1;
                        r_sr    <= w_sr_next;
                        r_beat  <= r_beat + 1'b1;
                        r_last  <= 1'b0;
                        if (r_beat == c_last_beat) begin
`ifdef CONV_ENC_TAIL_TERM_EN
                            r_fsm  <= S_TAIL;
`else
                            r_last <= 1'b1;
                            r_fsm  <= S_FLUSH;
`endif
                        end
                    end else if (i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                    end
                end
                S_TAIL: begin
                    if (w_out_free) begin
                        r_data      <= w_enc;
                        r_nbits     <= w_nbits;
                        r_valid     <= 1'b1;
                        r_sr        <= w_sr_next;
                        r_last      <= w_tail_last;
                        r_tail_left <= r_tail_left - c_in_w;
                        if (w_tail_last) begin
                            r_fsm <= S_FLUSH;
                        end
                    end
                end
                S_FLUSH: begin
                    if (r_valid && i_ready) begin
                        r_valid <= 1'b0;
                        r_last  <= 1'b0;
                        r_done  <= 1'b1;
                        r_final <= r_sr;
                        r_fsm   <= S_DONE;
                    end
                end
                S_DONE: begin
                    r_final <= '0;
                    r_fsm   <= S_IDLE;
                end
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

    assign o_data        = r_data;
    assign o_nbits       = r_nbits;
    assign o_valid       = r_valid;
    assign o_last        = r_last;
    assign o_final_state = r_final;
    assign o_done        = r_done;

endmodule
`default_nettype wire

// File: tb/tb_conv_encoder_stream.sv
`default_nettype none
// ============================================================================
//  Module   : tb_conv_encoder_stream
//  Brief    : Directed scoreboard bench for conv_encoder_stream (tail build
//             selected by CONV_ENC_TAIL_TERM_EN).
//  Revision : 1.0 - initial release
// ============================================================================
module tb_conv_encoder_stream;
    localparam int K_MAX = 9;
    localparam int R_MAX = 3;
    localparam int IN_W  = 4;
    localparam int FRAME_BEATS = 4;
    localparam int KW  = $clog2(K_MAX+1);
    localparam int NBW = $clog2(R_MAX*IN_W+1);
`ifdef CONV_ENC_TAIL_TERM_EN
    localparam bit TAIL_EN = 1'b1;
`else
    localparam bit TAIL_EN = 1'b0;
`endif

    logic                   sys_clk;
    logic                   rst;
    logic                   i_start;
    logic                   i_code_rate;
    logic [K_MAX*R_MAX-1:0] i_gen_poly_flat;
    logic [KW-1:0]          i_constraint_len;
    logic [K_MAX-2:0]       i_prv_encoder_state;
    logic [IN_W-1:0]        i_data;
    logic                   i_valid;
    logic                   o_ready;
    logic [R_MAX*IN_W-1:0]  o_data;
    logic [NBW-1:0]         o_nbits;
    logic                   o_valid;
    logic                   i_ready;
    logic                   o_last;
    logic [K_MAX-2:0]       o_final_state;
    logic                   o_done;

    conv_encoder_stream #(
        .K_MAX(K_MAX), .R_MAX(R_MAX), .IN_W(IN_W), .FRAME_BEATS(FRAME_BEATS)
    ) dut (
        .sys_clk(sys_clk), .rst(rst), .i_start(i_start), .i_code_rate(i_code_rate),
        .i_gen_poly_flat(i_gen_poly_flat), .i_constraint_len(i_constraint_len),
        .i_prv_encoder_state(i_prv_encoder_state), .i_data(i_data), .i_valid(i_valid),
        .o_ready(o_ready), .o_data(o_data), .o_nbits(o_nbits), .o_valid(o_valid),
        .i_ready(i_ready), .o_last(o_last), .o_final_state(o_final_state), .o_done(o_done)
    );

    initial sys_clk = 1'b0;
    always #5 sys_clk = ~sys_clk;

    typedef struct packed {
        logic [R_MAX*IN_W-1:0] data;
        logic [NBW-1:0]        nbits;
        logic                  last;
    } beat_t;

    beat_t q[$];
    beat_t mon_exp;
    int n_cmp = 0;
    int n_err = 0;

    // Reference model: m_hist[k] is the input bit k+1 steps in the past.
    logic             m_hist [K_MAX];
    logic [K_MAX-1:0] m_poly [R_MAX];
    int               m_k;
    int               m_r;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [K_MAX-2:0] model_final();
        logic [K_MAX-2:0] s;
        s = '0;
        for (int k = 0; k < K_MAX-1; k++) s[k] = (k < m_k-1) ? m_hist[k] : 1'b0;
        return s;
    endfunction

    task automatic model_beat(input logic [IN_W-1:0] d, input int nv, input logic last);
        beat_t e;
        logic  b;
        logic  acc;
        e = '0;
        for (int i = 0; i < IN_W; i++) begin
            b = (i < nv) ? d[i] : 1'b0;
            if (i < nv) begin
                for (int j = 0; j < m_r; j++) begin
                    acc = m_poly[j][0] & b;
                    for (int k = 1; k < m_k; k++) acc = acc ^ (m_poly[j][k] & m_hist[k-1]);
                    e.data[R_MAX*i+j] = acc;
                end
            end
            for (int k = K_MAX-1; k > 0; k--) m_hist[k] = m_hist[k-1];
            m_hist[0] = b;
        end
        e.nbits = NBW'(m_r * nv);
        e.last  = last;
        q.push_back(e);
    endtask

    task automatic model_tail();
        int rem;
        int n;
        rem = m_k - 1;
        while (rem > 0) begin
            n = (rem >= IN_W) ? IN_W : rem;
            model_beat('0, n, rem <= IN_W);
            rem = rem - n;
        end
    endtask

    task automatic start_frame(input logic rate, input logic [K_MAX-1:0] g0, input logic [K_MAX-1:0] g1,
                               input logic [K_MAX-1:0] g2, input int k, input logic [K_MAX-2:0] prv);
        i_code_rate         = rate;
        i_gen_poly_flat     = {g2, g1, g0};
        i_constraint_len    = KW'(k);
        i_prv_encoder_state = prv;
        i_start             = 1'b1;
        m_k = (k < 3 || k > K_MAX) ? K_MAX : k;
        m_r = rate ? 3 : 2;
        m_poly[0] = g0; m_poly[1] = g1; m_poly[2] = g2;
        for (int j = 0; j < K_MAX; j++) m_hist[j] = (j < m_k-1) ? prv[j] : 1'b0;
        @(posedge sys_clk); #1;
        i_start = 1'b0;
    endtask

    task automatic send_beat(input logic [IN_W-1:0] d, input logic last_data);
        int t;
        t = 0;
        i_data  = d;
        i_valid = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (o_ready) break;
            t++;
            if (t > 100) begin
                chk("ready_timeout", 64'(o_ready), 64'd1);
                break;
            end
        end
        model_beat(d, IN_W, last_data && !TAIL_EN);
        if (last_data && TAIL_EN) model_tail();
        @(posedge sys_clk); #1;
        i_valid = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        int t;
        t = 0;
        i_ready = 1'b1;
        forever begin
            @(negedge sys_clk);
            if (o_done || t > 200) break;
            t++;
        end
        chk({tag, "_done"}, 64'(o_done), 64'd1);
        chk({tag, "_final_state"}, 64'(o_final_state), 64'(model_final()));
        chk({tag, "_queue_drained"}, 64'(q.size()), 64'd0);
        @(posedge sys_clk); #1;
        @(negedge sys_clk);
        chk({tag, "_done_pulse"}, 64'(o_done), 64'd0);
        @(posedge sys_clk); #1;
    endtask

    task automatic check_zero(input string tag);
        chk({tag, "_ready"}, 64'(o_ready), 64'd0);
        chk({tag, "_valid"}, 64'(o_valid), 64'd0);
        chk({tag, "_data"},  64'(o_data),  64'd0);
        chk({tag, "_nbits"}, 64'(o_nbits), 64'd0);
        chk({tag, "_last"},  64'(o_last),  64'd0);
        chk({tag, "_done"},  64'(o_done),  64'd0);
        chk({tag, "_final"}, 64'(o_final_state), 64'd0);
    endtask

    always @(negedge sys_clk) begin
        if (rst && o_valid && i_ready) begin
            if (q.size() == 0) begin
                chk("unexpected_beat", 64'(o_valid), 64'd0);
            end else begin
                mon_exp = q.pop_front();
                chk("beat_data",  64'(o_data),  64'(mon_exp.data));
                chk("beat_nbits", 64'(o_nbits), 64'(mon_exp.nbits));
                chk("beat_last",  64'(o_last),  64'(mon_exp.last));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed no finish, required finish before timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [IN_W-1:0]       rd [FRAME_BEATS];
        logic [R_MAX*IN_W-1:0] exp_d;
        logic                  saw;
        rst = 1'b0; i_start = 1'b0; i_code_rate = 1'b0; i_gen_poly_flat = '0;
        i_constraint_len = '0; i_prv_encoder_state = '0; i_data = '0;
        i_valid = 1'b0; i_ready = 1'b1;
        @(negedge sys_clk);
        check_zero("reset");
        @(posedge sys_clk); #1;
        rst = 1'b1;

        // Valid input in IDLE is ignored.
        i_valid = 1'b1; i_data = 4'hF;
        @(negedge sys_clk);
        chk("idle_ready", 64'(o_ready), 64'd0);
        @(posedge sys_clk); #1;
        i_valid = 1'b0;

        // Frame A: K=3 rate 1/2, nonzero poly 2 must not appear.
        start_frame(1'b0, 9'b111, 9'b101, 9'h1FF, 3, '0);
        send_beat(4'b1101, 1'b0);
        send_beat(4'h6, 1'b0);
        send_beat(4'hA, 1'b0);
        send_beat(4'h3, 1'b1);
        wait_done("frameA");

        // Frame B continues from the previous running state.
        start_frame(1'b0, 9'b111, 9'b101, 9'h000, 3, model_final());
        send_beat(4'h9, 1'b0);
        send_beat(4'h0, 1'b0);
        send_beat(4'hF, 1'b0);
        send_beat(4'h5, 1'b1);
        wait_done("frameB");

        // Frame C: K=9 rate 1/3 with a 5-cycle downstream stall.
        for (int b = 0; b < FRAME_BEATS; b++) rd[b] = IN_W'($urandom);
        start_frame(1'b1, 9'b111101101, 9'b110011011, 9'b100100111, 9, 8'h00);
        send_beat(rd[0], 1'b0);
        send_beat(rd[1], 1'b0);
        i_ready = 1'b0;
        i_valid = 1'b1;
        i_data  = rd[2];
        for (int c = 0; c < 5; c++) begin
            @(negedge sys_clk);
            exp_d = (q.size() > 0) ? q[0].data : '1;
            chk("stall_valid", 64'(o_valid), 64'd1);
            chk("stall_ready", 64'(o_ready), 64'd0);
            chk("stall_data",  64'(o_data),  64'(exp_d));
        end
        @(posedge sys_clk); #1;
        i_ready = 1'b1;
        send_beat(rd[2], 1'b0);
        send_beat(rd[3], 1'b1);
        wait_done("frameC");

        // Frame D: illegal K clamps to K_MAX; mid-frame config and start are ignored.
        start_frame(1'b0, 9'h1B5, 9'h0E7, 9'h155, 15, 8'hA5);
        i_code_rate = 1'b1; i_gen_poly_flat = 27'h5A5A5A5; i_constraint_len = KW'(3);
        i_prv_encoder_state = '0; i_start = 1'b1;
        send_beat(4'hC, 1'b0);
        i_start = 1'b0;
        send_beat(4'h7, 1'b0);
        send_beat(4'h1, 1'b0);
        send_beat(4'hE, 1'b1);
        wait_done("frameD");

        // Frame E: asynchronous reset during beat 3 abandons the frame.
        start_frame(1'b1, 9'h01F, 9'h01B, 9'h015, 5, 8'h0F);
        send_beat(4'h2, 1'b0);
        send_beat(4'hB, 1'b0);
        send_beat(4'h4, 1'b0);
        i_valid = 1'b1; i_data = 4'h8;
        #2;
        rst = 1'b0;
        #1;
        check_zero("midrst");
        q.delete();
        i_valid = 1'b0;
        @(posedge sys_clk); #1;
        rst = 1'b1;
        saw = 1'b0;
        for (int c = 0; c < 20; c++) begin
            @(negedge sys_clk);
            saw = saw | o_done | o_valid;
        end
        chk("midrst_no_activity", 64'(saw), 64'd0);
        @(posedge sys_clk); #1;

        // Frame F: clean frame after the reset.
        start_frame(1'b1, 9'h0AD, 9'h133, 9'h0F1, 8, 8'h3C);
        for (int b = 0; b < FRAME_BEATS; b++) send_beat(IN_W'($urandom), b == FRAME_BEATS-1);
        wait_done("frameF");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
